fifo_wrwidth_expander: RTL and testbench



---
 rtl/fifo_wrwidth_expander.sv | 95 +++++++++
 tb/tb_fifo_wrwidth_expander.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wrwidth_expander.sv
// Packs WRRATIO narrow input words into one wide word and writes it to a
// downstream FIFO. FLUSH emits a partially assembled word padded with PADWORD.
module fifo_wrwidth_expander #(
    parameter int                 WRWIDTH    = 32,
    parameter int                 WRRATIO    = 16,
    parameter int                 SHIFTORDER = 1,
    parameter logic [WRWIDTH-1:0] PADWORD    = '0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [WRWIDTH-1:0]         DIN,
    input  logic                       DIN_VALID,
    output logic                       DIN_READY,
    input  logic                       FLUSH,
    output logic [WRWIDTH*WRRATIO-1:0] DOUT,
    output logic                       WR_EN,
    input  logic                       FULL,
    output logic                       BUSY
);

    localparam int CW = (WRRATIO > 1) ? $clog2(WRRATIO) : 1;
    localparam int OW = WRWIDTH * WRRATIO;

    logic [CW-1:0] r_cnt;
    logic          r_out_pending;
    logic          r_flush_pend;
    logic [OW-1:0] r_buf;
    logic [OW-1:0] r_dout;

    logic          w_accept;
    logic          w_last_slot;
    logic          w_complete;
    logic          w_flush_fire;
    logic          w_emit;
    logic [CW:0]   w_filled;
    logic [OW-1:0] w_buf_next;
    logic [OW-1:0] w_emit_word;

    assign w_last_slot  = (r_cnt == CW'(WRRATIO - 1));
    assign DIN_READY    = ~(r_out_pending && (w_last_slot || r_flush_pend));
    assign WR_EN        = r_out_pending && ~FULL;
    assign BUSY         = (r_cnt != '0) || r_out_pending || r_flush_pend;
    assign DOUT         = r_dout;

    assign w_accept     = DIN_VALID && DIN_READY;
    assign w_complete   = w_accept && w_last_slot;
    assign w_flush_fire = r_flush_pend && ~r_out_pending;
    assign w_emit       = w_complete || w_flush_fire;
    assign w_filled     = {1'b0, r_cnt} + (CW + 1)'(w_accept);

    // Slots at or beyond the fill count are replaced by PADWORD on emit, so
    // stale buffer contents from an earlier word never leak into the output.
    for (genvar gi = 0; gi < WRRATIO; gi++) begin : g_slot
        localparam int POS = (SHIFTORDER != 0) ? (WRRATIO - 1 - gi) : gi;
        logic w_fill;
        logic w_keep;
        assign w_fill = w_accept && (r_cnt == CW'(gi));
        assign w_keep = ((CW + 1)'(gi) < w_filled);
        assign w_buf_next[POS*WRWIDTH +: WRWIDTH]  = w_fill ? DIN : r_buf[POS*WRWIDTH +: WRWIDTH];
        assign w_emit_word[POS*WRWIDTH +: WRWIDTH] = w_keep ? w_buf_next[POS*WRWIDTH +: WRWIDTH]
                                                            : PADWORD;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt         <= '0;
            r_out_pending <= 1'b0;
            r_flush_pend  <= 1'b0;
            r_buf         <= '0;
            r_dout        <= '0;
        end else begin
            if (w_accept) begin
                r_buf <= w_buf_next;
            end
            if (w_emit) begin
                // A FLUSH seen on an emitting edge is already satisfied by this word.
                r_dout        <= w_emit_word;
                r_out_pending <= 1'b1;
                r_cnt         <= '0;
                r_flush_pend  <= 1'b0;
            end else begin
                if (WR_EN) begin
                    r_out_pending <= 1'b0;
                end
                if (w_accept) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (FLUSH && ((r_cnt != '0) || w_accept)) begin
                    r_flush_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wrwidth_expander.sv
// Directed bench for fifo_wrwidth_expander: two instances (MSB-first and
// LSB-first packing) share stimulus; writes are captured at the falling edge.
module tb_fifo_wrwidth_expander;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  DIN;
    logic        DIN_VALID;
    logic        FLUSH;
    logic        FULL;

    logic        rdy1, wr1, busy1;
    logic        rdy0, wr0, busy0;
    logic [31:0] dout1, dout0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] q1[$];
    logic [31:0] q0[$];
    int          wc1[$];

    fifo_wrwidth_expander #(.WRWIDTH(8), .WRRATIO(4), .SHIFTORDER(1), .PADWORD(8'h00)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy1),
        .FLUSH(FLUSH), .DOUT(dout1), .WR_EN(wr1), .FULL(FULL), .BUSY(busy1)
    );

    fifo_wrwidth_expander #(.WRWIDTH(8), .WRRATIO(4), .SHIFTORDER(0), .PADWORD(8'h00)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy0),
        .FLUSH(FLUSH), .DOUT(dout0), .WR_EN(wr0), .FULL(FULL), .BUSY(busy0)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (wr1) begin
            q1.push_back(dout1);
            wc1.push_back(cyc);
            $display("write msb_first dout=%h cycle=%0d", dout1, cyc);
        end
        if (wr0) begin
            q0.push_back(dout0);
            $display("write lsb_first dout=%h cycle=%0d", dout0, cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f);
        DIN_VALID = v;
        DIN       = d;
        FLUSH     = f;
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        FLUSH     = 1'b0;
    endtask

    task automatic clear_q();
        q1.delete();
        q0.delete();
        wc1.delete();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; DIN = '0; DIN_VALID = 1'b0; FLUSH = 1'b0; FULL = 1'b0;
        #2;
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", rdy1); end
        checks++; if (wr1 !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b exp 0", wr1); end
        checks++; if (dout1 !== 32'h0) begin failures++; $display("FAIL reset_dout got %h exp 0", dout1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy1); end
        checks++; if (dout0 !== 32'h0) begin failures++; $display("FAIL reset_dout_lsb got %h exp 0", dout0); end
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        idle(1);
    endtask

    task automatic test_stream();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_q();
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got %b exp 1", i, rdy1); end
            drive(1'b1, v[i], 1'b0);
        end
        checks++; if (wr1 !== 1'b1) begin failures++; $display("FAIL stream_wr_en got %b exp 1", wr1); end
        checks++; if (dout1 !== 32'h11223344) begin failures++; $display("FAIL stream_dout_msb got %h exp 11223344", dout1); end
        checks++; if (dout0 !== 32'h44332211) begin failures++; $display("FAIL stream_dout_lsb got %h exp 44332211", dout0); end
        idle(1);
        checks++; if (wr1 !== 1'b0) begin failures++; $display("FAIL stream_wr_drop got %b exp 0", wr1); end
        idle(2);
        checks++; if (q1.size() != 1) begin failures++; $display("FAIL stream_write_count got %0d exp 1", q1.size()); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL stream_busy_end got %b exp 0", busy1); end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0);
        idle(3);
        checks++;
        if (q1.size() != 2 || q0.size() != 2) begin
            failures++; $display("FAIL b2b_write_count got %0d/%0d exp 2/2", q1.size(), q0.size());
        end else begin
            checks++; if (q1[0] !== 32'h01020304) begin failures++; $display("FAIL b2b_msb_w0 got %h exp 01020304", q1[0]); end
            checks++; if (q1[1] !== 32'h05060708) begin failures++; $display("FAIL b2b_msb_w1 got %h exp 05060708", q1[1]); end
            checks++; if (q0[0] !== 32'h04030201) begin failures++; $display("FAIL b2b_lsb_w0 got %h exp 04030201", q0[0]); end
            checks++; if (q0[1] !== 32'h08070605) begin failures++; $display("FAIL b2b_lsb_w1 got %h exp 08070605", q0[1]); end
            checks++; if (wc1[1] - wc1[0] != 4) begin failures++; $display("FAIL b2b_spacing got %0d exp 4", wc1[1] - wc1[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] v [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        logic       accepted = 1'b0;
        logic       r;
        clear_q();
        FULL = 1'b1;
        for (int i = 0; i < 7; i++) drive(1'b1, v[i], 1'b0);
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL bp_ready_low got %b exp 0", rdy1); end
        checks++; if (wr1 !== 1'b0) begin failures++; $display("FAIL bp_wr_held got %b exp 0", wr1); end
        checks++; if (dout1 !== 32'h11223344) begin failures++; $display("FAIL bp_dout_held got %h exp 11223344", dout1); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL bp_busy got %b exp 1", busy1); end
        DIN = 8'h88; DIN_VALID = 1'b1;
        idle(3);
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL bp_still_stalled got %b exp 0", rdy1); end
        checks++; if (q1.size() != 0) begin failures++; $display("FAIL bp_no_write got %0d exp 0", q1.size()); end
        FULL = 1'b0;
        #1;
        checks++; if (wr1 !== 1'b1) begin failures++; $display("FAIL bp_release_wr got %b exp 1", wr1); end
        for (int i = 0; i < 20 && !accepted; i++) begin
            r = rdy1;
            @(posedge CLK);
            #1;
            if (r) accepted = 1'b1;
        end
        DIN_VALID = 1'b0;
        checks++; if (!accepted) begin failures++; $display("FAIL bp_accept_timeout got 0 exp 1"); end
        idle(3);
        checks++;
        if (q1.size() != 2 || q0.size() != 2) begin
            failures++; $display("FAIL bp_write_count got %0d/%0d exp 2/2", q1.size(), q0.size());
        end else begin
            checks++; if (q1[0] !== 32'h11223344) begin failures++; $display("FAIL bp_w0 got %h exp 11223344", q1[0]); end
            checks++; if (q1[1] !== 32'h55667788) begin failures++; $display("FAIL bp_w1 got %h exp 55667788", q1[1]); end
            checks++; if (q0[1] !== 32'h88776655) begin failures++; $display("FAIL bp_lsb_w1 got %h exp 88776655", q0[1]); end
        end
    endtask

    task automatic test_flush_partial();
        clear_q();
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL fp_busy_pend got %b exp 1", busy1); end
        checks++; if (wr1 !== 1'b0) begin failures++; $display("FAIL fp_wr_early got %b exp 0", wr1); end
        idle(1);
        checks++; if (wr1 !== 1'b1) begin failures++; $display("FAIL fp_wr_en got %b exp 1", wr1); end
        checks++; if (dout1 !== 32'hAABB0000) begin failures++; $display("FAIL fp_dout_msb got %h exp aabb0000", dout1); end
        checks++; if (dout0 !== 32'h0000BBAA) begin failures++; $display("FAIL fp_dout_lsb got %h exp 0000bbaa", dout0); end
        idle(1);
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL fp_busy_clear got %b exp 0", busy1); end
        drive(1'b0, 8'h00, 1'b1);
        idle(2);
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL fp_idle_flush_busy got %b exp 0", busy1); end
        checks++; if (q1.size() != 1) begin failures++; $display("FAIL fp_write_count got %0d exp 1", q1.size()); end
    endtask

    task automatic test_flush_accept();
        clear_q();
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b1);
        idle(1);
        checks++; if (wr1 !== 1'b1) begin failures++; $display("FAIL fa_wr_en got %b exp 1", wr1); end
        checks++; if (dout1 !== 32'hAABB0000) begin failures++; $display("FAIL fa_dout got %h exp aabb0000", dout1); end
        idle(1);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b1);
        idle(3);
        checks++;
        if (q1.size() != 2) begin
            failures++; $display("FAIL fa_write_count got %0d exp 2", q1.size());
        end else begin
            checks++; if (q1[1] !== 32'h11223344) begin failures++; $display("FAIL fa_complete_word got %h exp 11223344", q1[1]); end
        end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL fa_busy_end got %b exp 0", busy1); end
    endtask

    task automatic test_reset_mid();
        clear_q();
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        #3;
        RESET_N = 1'b0;
        #1;
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rm_busy got %b exp 0", busy1); end
        checks++; if (dout1 !== 32'h0) begin failures++; $display("FAIL rm_dout got %h exp 0", dout1); end
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL rm_ready got %b exp 1", rdy1); end
        checks++; if (wr1 !== 1'b0) begin failures++; $display("FAIL rm_wr_en got %b exp 0", wr1); end
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        idle(1);
        drive(1'b1, 8'hC1, 1'b0);
        drive(1'b1, 8'hC2, 1'b0);
        drive(1'b1, 8'hC3, 1'b0);
        drive(1'b1, 8'hC4, 1'b0);
        idle(3);
        checks++;
        if (q1.size() != 1) begin
            failures++; $display("FAIL rm_write_count got %0d exp 1", q1.size());
        end else begin
            checks++; if (q1[0] !== 32'hC1C2C3C4) begin failures++; $display("FAIL rm_clean_word got %h exp c1c2c3c4", q1[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_backpressure();
        test_flush_partial();
        test_flush_accept();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
